// File: rtl/mouse_quad_enc.sv
`default_nettype none
// ============================================================================
// Module   : mouse_quad_enc
// Purpose  : Quadrature mouse encoder. Accepts signed 8-bit X/Y motion deltas,
//            accumulates them as pending steps and emits rate-limited 2-bit
//            Gray-code quadrature pairs, one step per axis every STEP_DIV
//            clocks at most.
// Ports    : w_clk     - system clock
//            w_arst_n  - asynchronous active-low reset
//            delta_vld - dx_in/dy_in valid this cycle
//            delta_rdy - block can accept a delta
//            dx_in     - signed horizontal delta
//            dy_in     - signed vertical delta
//            clr       - synchronous clear of both accumulators
//            quad_h    - horizontal {A,B}
//            quad_v    - vertical {A,B}
//            busy      - at least one accumulator non-zero
// Config   : MOUSE_QUAD_ENC_SAT_EN - when defined, delta_rdy is tied high and
//            each accumulator saturates instead of back-pressuring.
// Revision : 1.0 - initial release
// ============================================================================
module mouse_quad_enc #(
    parameter int STEP_DIV = 4250,
    parameter int ACC_W    = 10
) (
    input  logic       w_clk,
    input  logic       w_arst_n,
    input  logic       delta_vld,
    output logic       delta_rdy,
    input  logic [7:0] dx_in,
    input  logic [7:0] dy_in,
    input  logic       clr,
    output logic [1:0] quad_h,
    output logic [1:0] quad_v,
    output logic       busy
);

    localparam int TMR_W = $clog2(STEP_DIV);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STEP_DIV - 1);

    // Phase p -> {A,B}: 0:00, 1:01, 2:11, 3:10 (one bit changes per step)
    function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    // ------------------------------------------------------------------
    // Free-running step timer; tick is high while the counter sits at 0
    // ------------------------------------------------------------------
    logic [TMR_W-1:0] tmr;
    logic             tick;

    assign tick = (tmr == '0);

    always_ff @(posedge w_clk or negedge w_arst_n) begin
        if (!w_arst_n) begin
            tmr <= TMR_RELOAD;
        end else if (tick) begin
            tmr <= TMR_RELOAD;
        end else begin
            tmr <= tmr - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic            accept;
    logic [1:0][7:0] deltas;
    logic [3:0]      quad_all;
    logic [1:0]      nz;

    assign deltas = {dy_in, dx_in};
    assign accept = delta_vld & delta_rdy;

`ifdef MOUSE_QUAD_ENC_SAT_EN
    assign delta_rdy = 1'b1;
`else
    // Headroom of one full-scale delta (128) below the accumulator limit, so
    // an accepted delta can never overflow.
    localparam logic signed [ACC_W-1:0] RDY_MAX = ACC_W'((2 ** (ACC_W - 1)) - 129);
    localparam logic signed [ACC_W-1:0] RDY_MIN = ACC_W'(-((2 ** (ACC_W - 1)) - 129));

    logic [1:0] in_range;

    assign delta_rdy = &in_range;
`endif

    // ------------------------------------------------------------------
    // Per-axis accumulator, phase counter and registered output pair
    // ------------------------------------------------------------------
    for (genvar a = 0; a < 2; a++) begin : g_axis
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] acc_nxt;
        logic [1:0]              phase;
        logic [1:0]              phase_nxt;
        logic [1:0]              ab;
        logic                    step_up;
        logic                    step_dn;
        logic [7:0]              d;

        assign d = deltas[a];

        // Direction is decided on the pre-accept accumulator value
        assign step_up = tick & ~acc[ACC_W-1] & (acc != '0);
        assign step_dn = tick &  acc[ACC_W-1];

`ifdef MOUSE_QUAD_ENC_SAT_EN
        localparam logic signed [ACC_W+1:0] SUM_MAX = (ACC_W+2)'((2 ** (ACC_W - 1)) - 1);
        localparam logic signed [ACC_W+1:0] SUM_MIN = (ACC_W+2)'(-(2 ** (ACC_W - 1)));

        // Two guard bits keep acc + delta - dir exact before clamping
        logic signed [ACC_W+1:0] sum;

        always_comb begin
            sum = {{2{acc[ACC_W-1]}}, acc};
            if (accept) begin
                sum = sum + {{(ACC_W-6){d[7]}}, d};
            end
            if (step_up) begin
                sum = sum - 1'b1;
            end else if (step_dn) begin
                sum = sum + 1'b1;
            end
            if (sum > SUM_MAX) begin
                acc_nxt = SUM_MAX[ACC_W-1:0];
            end else if (sum < SUM_MIN) begin
                acc_nxt = SUM_MIN[ACC_W-1:0];
            end else begin
                acc_nxt = sum[ACC_W-1:0];
            end
        end
`else
        always_comb begin
            acc_nxt = acc;
            if (accept) begin
                acc_nxt = acc_nxt + {{(ACC_W-8){d[7]}}, d};
            end
            if (step_up) begin
                acc_nxt = acc_nxt - 1'b1;
            end else if (step_dn) begin
                acc_nxt = acc_nxt + 1'b1;
            end
        end

        assign in_range[a] = (acc <= RDY_MAX) && (acc >= RDY_MIN);
`endif

        // A clear discards the pending steps, so the phase must not move on
        // that cycle either.
        always_comb begin
            phase_nxt = phase;
            if (!clr) begin
                if (step_up) begin
                    phase_nxt = phase + 2'd1;
                end else if (step_dn) begin
                    phase_nxt = phase - 2'd1;
                end
            end
        end

        always_ff @(posedge w_clk or negedge w_arst_n) begin
            if (!w_arst_n) begin
                acc   <= '0;
                phase <= '0;
                ab    <= '0;
            end else begin
                acc   <= clr ? '0 : acc_nxt;
                phase <= phase_nxt;
                ab    <= phase_to_ab(phase_nxt);
            end
        end

        assign quad_all[2*a +: 2] = ab;
        assign nz[a]              = (acc != '0);
    end

    assign quad_h = quad_all[1:0];
    assign quad_v = quad_all[3:2];
    assign busy   = |nz;

endmodule
`default_nettype wire

// File: tb/tb_mouse_quad_enc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mouse_quad_enc
// Purpose  : Self-checking bench for mouse_quad_enc (STEP_DIV=8, ACC_W=10).
//            Table of {delta, check cycle, expected outputs} records plus
//            hand-written sequences for tick-coincident accept, back-pressure /
//            saturation, clear and asynchronous reset.
//            Expectations follow MOUSE_QUAD_ENC_SAT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mouse_quad_enc;

    localparam int SD    = 8;
    localparam int ACC_W = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld = 1'b0;
    logic       rdy;
    logic [7:0] dx = '0;
    logic [7:0] dy = '0;
    logic       clr = 1'b0;
    logic [1:0] qh;
    logic [1:0] qv;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mouse_quad_enc #(
        .STEP_DIV (SD),
        .ACC_W    (ACC_W)
    ) dut (
        .w_clk     (clk),
        .w_arst_n  (rst_n),
        .delta_vld (vld),
        .delta_rdy (rdy),
        .dx_in     (dx),
        .dy_in     (dy),
        .clr       (clr),
        .quad_h    (qh),
        .quad_v    (qv),
        .busy      (busy)
    );

    typedef struct {
        bit          start;  // reset, check, then apply dx/dy for one beat
        logic [7:0]  dx;
        logic [7:0]  dy;
        int          at;     // negedge index after reset release
        logic [1:0]  h;
        logic [1:0]  v;
        logic        b;
        logic        r;
    } vec_t;

    vec_t tbl[$];

    task automatic next();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld   = 1'b0;
        clr   = 1'b0;
        dx    = '0;
        dy    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic chk(input string name, input logic [1:0] h, input logic [1:0] v,
                       input logic b, input logic r);
        n_vec++;
        if ({qh, qv, busy, rdy} !== {h, v, b, r}) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got h=%b v=%b busy=%b rdy=%b, want h=%b v=%b busy=%b rdy=%b",
                     name, cyc, qh, qv, busy, rdy, h, v, b, r);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic beat(input logic [7:0] x, input logic [7:0] y);
        vld = 1'b1;
        dx  = x;
        dy  = y;
        next();
        vld = 1'b0;
        dx  = '0;
        dy  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   changes;
        int   exp_steps;
        logic [1:0] prev;
        logic [1:0] exp_end;

        // dx=+3: 00->01->11->10 at edges 8,16,24; busy falls after third step
        tbl.push_back('{1, 8'sd3,  8'sd0,  0, 2'b00, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0,  1, 2'b00, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0,  7, 2'b00, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0,  8, 2'b01, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0, 15, 2'b01, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0, 16, 2'b11, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0, 23, 2'b11, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0, 24, 2'b10, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0, 40, 2'b10, 2'b00, 1'b0, 1'b1});
        // dx=-2: 00->10->11, then idle
        tbl.push_back('{1, -8'sd2, 8'sd0,  0, 2'b00, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0,  8, 2'b10, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0, 16, 2'b11, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0, 24, 2'b11, 2'b00, 1'b0, 1'b1});
        // dx=+1, dy=-1 in one beat: both change on the same edge
        tbl.push_back('{1, 8'sd1,  -8'sd1, 0, 2'b00, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0,  7, 2'b00, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0,  8, 2'b01, 2'b10, 1'b0, 1'b1});
        // dx=-1, dy=+2
        tbl.push_back('{1, -8'sd1, 8'sd2,  0, 2'b00, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0,  8, 2'b10, 2'b01, 1'b1, 1'b1});
        tbl.push_back('{0, 8'sd0,  8'sd0, 16, 2'b10, 2'b11, 1'b0, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].start) do_reset();
            while (cyc < tbl[i].at) next();
            chk($sformatf("vec%0d", i), tbl[i].h, tbl[i].v, tbl[i].b, tbl[i].r);
            if (tbl[i].start) beat(tbl[i].dx, tbl[i].dy);
        end

        // acc_x=1, then dx=+1 accepted on the tick cycle: two steps total
        do_reset();
        beat(8'sd1, 8'sd0);
        while (cyc < SD - 1) next();
        beat(8'sd1, 8'sd0);
        chk("tick_accept_e1", 2'b01, 2'b00, 1'b1, 1'b1);
        while (cyc < 2 * SD) next();
        chk("tick_accept_e2", 2'b11, 2'b00, 1'b0, 1'b1);
        while (cyc < 3 * SD) next();
        chk("tick_accept_e3", 2'b11, 2'b00, 1'b0, 1'b1);

        // Five beats of dx=+127 with vld held
        do_reset();
        vld = 1'b1;
        dx  = 8'sd127;
        repeat (5) next();
        vld = 1'b0;
        dx  = '0;
`ifdef MOUSE_QUAD_ENC_SAT_EN
        chk("full_rdy", 2'b00, 2'b00, 1'b1, 1'b1);
        exp_steps = 511;
        exp_end   = 2'b10;
`else
        chk("full_rdy", 2'b00, 2'b00, 1'b1, 1'b0);
        exp_steps = 508;
        exp_end   = 2'b00;
`endif
        changes = 0;
        prev    = qh;
        while (busy && cyc < 6000) begin
            next();
            if (qh != prev) changes++;
            prev = qh;
`ifndef MOUSE_QUAD_ENC_SAT_EN
            // 125 steps bring acc from 508 to 383 at edge 1000
            if (cyc == 125 * SD - 1) chk_int("rdy_before_headroom", int'(rdy), 0);
            if (cyc == 125 * SD)     chk_int("rdy_at_headroom", int'(rdy), 1);
`endif
        end
        chk_int("total_steps", changes, exp_steps);
        chk("full_drain", exp_end, 2'b00, 1'b0, 1'b1);

        // Mid-stream clr: busy drops next cycle, phases hold
        do_reset();
        beat(8'sd5, -8'sd3);
        while (cyc < SD) next();
        chk("clr_pre", 2'b01, 2'b10, 1'b1, 1'b1);
        while (cyc < SD + 2) next();
        clr = 1'b1;
        next();
        clr = 1'b0;
        chk("clr_next", 2'b01, 2'b10, 1'b0, 1'b1);
        while (cyc < 3 * SD) next();
        chk("clr_hold", 2'b01, 2'b10, 1'b0, 1'b1);

        // Mid-stream asynchronous reset
        do_reset();
        beat(8'sd5, 8'sd0);
        while (cyc < SD + 4) next();
        chk("arst_pre", 2'b01, 2'b00, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_now", 2'b00, 2'b00, 1'b0, 1'b1);
        next();
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 2 * SD) next();
        chk("arst_after", 2'b00, 2'b00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
